chop_demod_integ: RTL and testbench
===================================

Name: chop_demod_integ

Overview:
- Receive-side counterpart of the chopper generator; consumes ADC samples taken through the chopped front end.
- Uses the delayed chop phase and the data-hold strobe from the generator to sign-demodulate each sample and to drop settling samples.
- Accumulates a saturating signed integral for the interlock processing chain.
- Reports the residual offset measured over each full chop period.

Parameters:
DATA_W, 18, ADC sample width, two's complement
INT_W, 32, integral accumulator width, signed
CNT_W, 16, sample counter width for the per-period count

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
adc_data_i  in  DATA_W  signed ADC sample
adc_valid_i  in  1  single-cycle strobe, adc_data_i valid
chop_i  in  1  delayed chop phase from generator, aligned to ADC data
hold_i  in  1  delayed hold strobe from generator; high = discard sample
chop_default_i  in  1  chop level meaning "non-inverted" phase
int_en_i  in  1  integration enable
int_clr_i  in  1  synchronous clear of integral and saturation flag
demod_o  out  DATA_W  last demodulated sample
demod_valid_o  out  1  strobe, demod_o updated
integral_o  out  INT_W  running integral
int_sat_o  out  1  sticky: integral has saturated
offset_sum_o  out  INT_W  sum of raw non-held samples over last full chop period
offset_cnt_o  out  CNT_W  number of samples in offset_sum_o
offset_valid_o  out  1  one-cycle strobe when offset_* update
proto_err_o  out  1  sticky: chop_i changed on a sample with hold_i low

Behaviour:
- Reset values: all outputs 0. Internal prev_chop = chop_default_i sampled at reset release; period accumulators = 0.
- chop_i and hold_i are changed by the generator on the falling clock edge. They are sampled only on the rising edge, in cycles where adc_valid_i = 1.
- Demodulation:
  - If chop_i == chop_default_i, d = x; otherwise d = -x.
  - -(most negative value) saturates to the most positive DATA_W value.
- Output timing:
  - demod_o and demod_valid_o are registered, 1-cycle latency from adc_valid_i.
  - demod_o and demod_valid_o update even when hold_i = 1, so the trace shows the held samples.
- Integral:
  - On a valid sample with hold_i = 0 and int_en_i = 1: integral += sign_extend(d).
  - Result clamps to [-2^(INT_W-1), 2^(INT_W-1)-1]; on a clamp, int_sat_o is set (sticky).
  - integral_o has 2-cycle latency from adc_valid_i.
  - int_clr_i zeroes integral_o and int_sat_o, and wins over a same-cycle accumulate.
- Offset estimator:
  - Accumulates raw x, not d, for valid samples with hold_i = 0, into period_sum (INT_W, saturating) and period_cnt (CNT_W, saturates at all-ones).
  - Period end: a valid sample where chop_i == chop_default_i and prev_chop != chop_default_i, i.e. return to the default phase.
  - At period end the block does three things:
    - latches offset_sum_o and offset_cnt_o from the accumulators, excluding the current sample;
    - pulses offset_valid_o for one cycle;
    - restarts the accumulators with the current sample (counted only if hold_i = 0).
  - prev_chop updates on every valid sample.
- Chop disabled: chop_i stays at default, so no period end occurs and offset_* hold their last values. The integral keeps accumulating the non-inverted samples.
- Protocol check: on a valid sample where chop_i != prev_chop and hold_i = 0, set proto_err_o (sticky). It clears only on rst; int_clr_i does not clear it.
- Simultaneous events: int_clr_i together with a period end leaves the offset path unaffected.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). There is no partial offset report.

Test Plan:
- Defaults, chop_default_i = 0, chop_i = 0, hold_i = 0, int_en_i = 1, 10 samples of +100 -> demod_o = 100, integral_o = 1000, offset_valid_o never pulses.
- Square chop of 8 samples per phase, hold_i high for the first 3 samples after each edge, input = +50 in phase 0 and -50 in phase 1 -> every non-held d = +50, integral_o = 500 per period, offset_sum_o = 0 and offset_cnt_o = 10 pulsed once per period.
- adc_data_i = -131072 with chop_i inverted -> demod_o = 131071, no wrap.
- Integral preloaded near +2^31-1 and driven with repeated positive samples -> integral_o = 2147483647, int_sat_o = 1. Then pulse int_clr_i -> integral_o = 0, int_sat_o = 0.
- chop_i toggled with hold_i = 0 -> proto_err_o = 1 and stays set. A subsequent int_clr_i leaves it at 1; rst clears it.
- rst asserted mid-period after 5 accumulated samples -> all outputs 0 immediately. After release, the first offset_valid_o reports only samples taken after reset.

Source files
------------

// File: rtl/chop_demod_integ_if.sv
// Sample/result bundle between the chopped ADC front end and the chop demodulator/integrator.
interface chop_demod_integ_if #(
    parameter int DATA_W = 18,
    parameter int INT_W  = 32,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] adc_data_i;
    logic              adc_valid_i;
    logic              chop_i;
    logic              hold_i;
    logic              chop_default_i;
    logic              int_en_i;
    logic              int_clr_i;
    logic [DATA_W-1:0] demod_o;
    logic              demod_valid_o;
    logic [INT_W-1:0]  integral_o;
    logic              int_sat_o;
    logic [INT_W-1:0]  offset_sum_o;
    logic [CNT_W-1:0]  offset_cnt_o;
    logic              offset_valid_o;
    logic              proto_err_o;

    modport master (
        output adc_data_i, adc_valid_i, chop_i, hold_i, chop_default_i, int_en_i, int_clr_i,
        input  demod_o, demod_valid_o, integral_o, int_sat_o,
        input  offset_sum_o, offset_cnt_o, offset_valid_o, proto_err_o
    );

    modport slave (
        input  adc_data_i, adc_valid_i, chop_i, hold_i, chop_default_i, int_en_i, int_clr_i,
        output demod_o, demod_valid_o, integral_o, int_sat_o,
        output offset_sum_o, offset_cnt_o, offset_valid_o, proto_err_o
    );
endinterface

// File: rtl/chop_demod_integ.sv
// Sign-demodulates chopped ADC samples, integrates them with saturation and
// measures the raw residual offset over each full chop period.
module chop_demod_integ #(
    parameter int DATA_W = 18,
    parameter int INT_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    chop_demod_integ_if.slave  bus
);
    localparam logic [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [INT_W-1:0]  I_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0]  I_MIN = {1'b1, {(INT_W-1){1'b0}}};

    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] d_next;
    logic [INT_W-1:0]  x_ext;
    logic [INT_W-1:0]  d_ext;
    logic [INT_W:0]    psum_wide;
    logic [INT_W:0]    int_wide;
    logic [INT_W-1:0]  psum_next;
    logic [INT_W-1:0]  int_next;
    logic              int_ovf;
    logic [INT_W-1:0]  period_sum;
    logic [CNT_W-1:0]  period_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              prev_chop;
    logic              prev_valid;
    logic              prev_eff;
    logic              invert;
    logic              period_end;
    logic              acc_pend;

    function automatic logic [INT_W-1:0] clamp(input logic [INT_W:0] w);
        if (w[INT_W] != w[INT_W-1])
            return w[INT_W] ? I_MIN : I_MAX;
        return w[INT_W-1:0];
    endfunction

    always_comb begin
        x        = bus.adc_data_i;
        invert   = (bus.chop_i != bus.chop_default_i);
        // prev_chop is only meaningful once the first post-reset edge has captured the default
        prev_eff = prev_valid ? prev_chop : bus.chop_default_i;
        d_next   = x;
        if (invert)
            d_next = (x == D_MIN) ? D_MAX : (~x + 1'b1);
        period_end = bus.adc_valid_i && !invert && (prev_eff != bus.chop_default_i);

        x_ext     = {{(INT_W-DATA_W){x[DATA_W-1]}}, x};
        d_ext     = {{(INT_W-DATA_W){bus.demod_o[DATA_W-1]}}, bus.demod_o};
        psum_wide = {period_sum[INT_W-1], period_sum} + {x_ext[INT_W-1], x_ext};
        psum_next = clamp(psum_wide);
        int_wide  = {bus.integral_o[INT_W-1], bus.integral_o} + {d_ext[INT_W-1], d_ext};
        int_next  = clamp(int_wide);
        int_ovf   = (int_wide[INT_W] != int_wide[INT_W-1]);
        cnt_next  = (period_cnt == {CNT_W{1'b1}}) ? period_cnt : period_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.demod_o        <= '0;
            bus.demod_valid_o  <= 1'b0;
            bus.integral_o     <= '0;
            bus.int_sat_o      <= 1'b0;
            bus.offset_sum_o   <= '0;
            bus.offset_cnt_o   <= '0;
            bus.offset_valid_o <= 1'b0;
            bus.proto_err_o    <= 1'b0;
            period_sum         <= '0;
            period_cnt         <= '0;
            prev_chop          <= 1'b0;
            prev_valid         <= 1'b0;
            acc_pend           <= 1'b0;
        end else begin
            bus.demod_valid_o  <= bus.adc_valid_i;
            bus.offset_valid_o <= 1'b0;
            acc_pend           <= bus.adc_valid_i && !bus.hold_i && bus.int_en_i;
            if (!prev_valid) begin
                prev_chop  <= bus.chop_default_i;
                prev_valid <= 1'b1;
            end
            if (bus.adc_valid_i) begin
                bus.demod_o <= d_next;
                prev_chop   <= bus.chop_i;
                if ((bus.chop_i != prev_eff) && !bus.hold_i)
                    bus.proto_err_o <= 1'b1;
                if (period_end) begin
                    bus.offset_sum_o   <= period_sum;
                    bus.offset_cnt_o   <= period_cnt;
                    bus.offset_valid_o <= 1'b1;
                    period_sum         <= bus.hold_i ? '0 : x_ext;
                    period_cnt         <= bus.hold_i ? '0 : {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (!bus.hold_i) begin
                    period_sum <= psum_next;
                    period_cnt <= cnt_next;
                end
            end
            // integration runs one cycle behind demod_o, so a clear here always wins
            if (bus.int_clr_i) begin
                bus.integral_o <= '0;
                bus.int_sat_o  <= 1'b0;
            end else if (acc_pend) begin
                bus.integral_o <= int_next;
                if (int_ovf)
                    bus.int_sat_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_chop_demod_integ.sv
// Directed bench for chop_demod_integ with a behavioural model feeding expected-result queues.
module tb_chop_demod_integ;
    localparam int DATA_W = 18;
    localparam int INT_W  = 32;
    localparam int CNT_W  = 16;
    localparam longint I_MAX = 64'sd2147483647;
    localparam longint I_MIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    chop_demod_integ_if #(.DATA_W(DATA_W), .INT_W(INT_W), .CNT_W(CNT_W)) bus ();

    chop_demod_integ #(.DATA_W(DATA_W), .INT_W(INT_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    bit     m_prev;
    longint m_int;
    bit     m_sat;
    longint m_psum;
    longint m_pcnt;
    bit     m_err;
    longint q_demod[$];
    longint q_osum[$];
    longint q_ocnt[$];

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint clamp32(input longint v);
        if (v > I_MAX) return I_MAX;
        if (v < I_MIN) return I_MIN;
        return v;
    endfunction

    task automatic model_reset();
        m_prev = bus.chop_default_i;
        m_int = 0; m_sat = 0; m_psum = 0; m_pcnt = 0; m_err = 0;
        q_demod.delete(); q_osum.delete(); q_ocnt.delete();
    endtask

    task automatic sample(input longint x, input bit c, input bit h);
        longint d;
        bit     pe;
        @(negedge clk);
        bus.adc_data_i  = DATA_W'(x);
        bus.adc_valid_i = 1'b1;
        bus.chop_i      = c;
        bus.hold_i      = h;
        d = (c != bus.chop_default_i) ? ((x == -131072) ? 131071 : -x) : x;
        q_demod.push_back(d);
        if (c != m_prev && !h) m_err = 1;
        pe = (c == bus.chop_default_i) && (m_prev != bus.chop_default_i);
        if (pe) begin
            q_osum.push_back(m_psum);
            q_ocnt.push_back(m_pcnt);
            m_psum = h ? 0 : x;
            m_pcnt = h ? 0 : 1;
        end else if (!h) begin
            m_psum = clamp32(m_psum + x);
            m_pcnt = (m_pcnt == 65535) ? 65535 : m_pcnt + 1;
        end
        m_prev = c;
        if (!h && bus.int_en_i) begin
            if (m_int + d != clamp32(m_int + d)) m_sat = 1;
            m_int = clamp32(m_int + d);
        end
        @(posedge clk);
        #1;
        check("demod_valid", bus.demod_valid_o, 1);
        check("demod", $signed(bus.demod_o), q_demod.pop_front());
        check("offset_valid", bus.offset_valid_o, q_osum.size() != 0);
        if (bus.offset_valid_o && q_osum.size() != 0) begin
            check("offset_sum", $signed(bus.offset_sum_o), q_osum.pop_front());
            check("offset_cnt", bus.offset_cnt_o, q_ocnt.pop_front());
        end else if (q_osum.size() != 0) begin
            void'(q_osum.pop_front());
            void'(q_ocnt.pop_front());
        end
        check("proto_err", bus.proto_err_o, m_err);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.adc_valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_integral(input string tag);
        check({tag, "_integral"}, $signed(bus.integral_o), m_int);
        check({tag, "_sat"}, bus.int_sat_o, m_sat);
    endtask

    task automatic clear_integral();
        @(negedge clk);
        bus.int_clr_i = 1'b1;
        @(negedge clk);
        bus.int_clr_i = 1'b0;
        #1;
        m_int = 0;
        m_sat = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_demod"}, bus.demod_o, 0);
        check({tag, "_demod_valid"}, bus.demod_valid_o, 0);
        check({tag, "_integral"}, bus.integral_o, 0);
        check({tag, "_int_sat"}, bus.int_sat_o, 0);
        check({tag, "_offset_sum"}, bus.offset_sum_o, 0);
        check({tag, "_offset_cnt"}, bus.offset_cnt_o, 0);
        check({tag, "_offset_valid"}, bus.offset_valid_o, 0);
        check({tag, "_proto_err"}, bus.proto_err_o, 0);
    endtask

    initial begin
        bus.adc_data_i     = '0;
        bus.adc_valid_i    = 1'b0;
        bus.chop_i         = 1'b0;
        bus.hold_i         = 1'b0;
        bus.chop_default_i = 1'b0;
        bus.int_en_i       = 1'b1;
        bus.int_clr_i      = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // chop idle at default: plain accumulation, no period end
        for (int i = 0; i < 10; i++) sample(100, 0, 0);
        idle(2);
        check_integral("flat");
        check("flat_integral_abs", $signed(bus.integral_o), 1000);

        bus.int_en_i = 1'b0;
        for (int i = 0; i < 3; i++) sample(77, 0, 0);
        idle(2);
        check_integral("int_disabled");
        bus.int_en_i = 1'b1;

        // square chop with settling holds; each return to phase 0 closes a period
        for (int p = 0; p < 2; p++)
            for (int ph = 0; ph < 2; ph++)
                for (int k = 0; k < 8; k++)
                    sample(ph ? -50 : 50, ph[0], k < 3);
        sample(50, 0, 1);
        idle(2);
        check_integral("square");
        check("square_integral_abs", $signed(bus.integral_o), 2000);
        check("square_offset_sum", $signed(bus.offset_sum_o), 0);
        check("square_offset_cnt", bus.offset_cnt_o, 10);

        // most negative sample inverted must not wrap
        sample(-131072, 1, 1);
        check("neg_full_scale", $signed(bus.demod_o), 131071);
        sample(0, 0, 1);
        idle(2);

        // drive integral into positive clamp, then clear
        clear_integral();
        check_integral("clr1");
        for (int i = 0; i < 16400; i++) sample(131071, 0, 0);
        idle(2);
        check_integral("sat");
        check("sat_integral_abs", $signed(bus.integral_o), I_MAX);
        clear_integral();
        check_integral("clr2");

        // chop edge without hold flags a protocol error, which int_clr cannot clear
        sample(10, 1, 0);
        sample(10, 1, 0);
        sample(10, 0, 0);
        idle(2);
        check("proto_set", bus.proto_err_o, 1);
        clear_integral();
        check("proto_after_clr", bus.proto_err_o, 1);
        check_integral("clr3");

        // async reset mid-period drops the partial accumulation
        for (int i = 0; i < 5; i++) sample(9, 0, 0);
        @(negedge clk);
        bus.adc_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) sample(7, 0, 0);
        sample(7, 1, 1);
        for (int i = 0; i < 3; i++) sample(7, 1, 0);
        sample(7, 0, 1);
        idle(2);
        check("post_rst_sum", $signed(bus.offset_sum_o), 49);
        check("post_rst_cnt", bus.offset_cnt_o, 7);
        check("post_rst_proto", bus.proto_err_o, 0);
        check_integral("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
